// File: rtl/gate_sweep_ctrl.sv
// Sweep controller for a 2-input combinational gate: drives all four input vectors,
// samples the gate output after a settle time, and checks it against a truth table.
// Optional saturating mismatch counter output err_cnt when GATE_SWEEP_ERRCNT_EN is defined.
module gate_sweep_ctrl #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter logic [3:0]  EXPECT      = 4'b1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dut_y,
   output logic       dut_a,
   output logic       dut_b,
   output logic [1:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
`ifdef GATE_SWEEP_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   typedef enum logic {
      S_IDLE,
      S_DRIVE
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] k_q, k_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] mask_q, mask_d;
   logic       sample_miss;

`ifdef GATE_SWEEP_ERRCNT_EN
   logic [7:0] err_q, err_d;
`endif

   assign sample_miss = (dut_y != EXPECT[k_q]);

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      mask_d  = mask_q;
`ifdef GATE_SWEEP_ERRCNT_EN
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRIVE;
               cnt_d   = 8'd0;
               k_d     = 2'd0;
               mask_d  = 4'b0000;
               pass_d  = 1'b0;
            end
         end
         S_DRIVE: begin
            if (cnt_q == HOLD_LAST) begin
               if (sample_miss) begin
                  mask_d[k_q] = 1'b1;
`ifdef GATE_SWEEP_ERRCNT_EN
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
               end
               cnt_d = 8'd0;
               if (k_q == 2'd3) begin
                  // pass must include the verdict of the last vector sampled at this edge
                  state_d = S_IDLE;
                  k_d     = 2'd0;
                  done_d  = 1'b1;
                  pass_d  = (mask_d == 4'b0000);
               end else begin
                  k_d = k_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         k_q     <= 2'd0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= 4'b0000;
`ifdef GATE_SWEEP_ERRCNT_EN
         err_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
`ifdef GATE_SWEEP_ERRCNT_EN
         err_q   <= err_d;
`endif
      end
   end

   // k_q returns to 0 in IDLE, so the gate inputs come straight from flops
   assign dut_a     = k_q[0];
   assign dut_b     = k_q[1];
   assign vec_idx   = k_q;
   assign busy      = (state_q == S_DRIVE);
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;
`ifdef GATE_SWEEP_ERRCNT_EN
   assign err_cnt   = err_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (H=2 AND table, H=1 XOR table) driving bench gates,
// compared every cycle against a sweep-timing model; err_cnt checked when GATE_SWEEP_ERRCNT_EN is defined.
module tb_gate_sweep_ctrl;

   localparam int G_AND = 0;
   localparam int G_OR  = 1;
   localparam int G_XOR = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] start_r;
   logic [1:0] y_w, a_w, b_w, busy_w, done_w, pass_w;
   logic [1:0] vi_w [2];
   logic [3:0] fm_w [2];
`ifdef GATE_SWEEP_ERRCNT_EN
   logic [7:0] ec_w [2];
`endif

   int         gate_sel [2];
   int         h_of [2]        = '{2, 1};
   logic [3:0] exp_of [2]      = '{4'b1000, 4'b0110};

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit cmp_en = 1'b0;
   logic [1:0] trace [16];

   // model state per instance
   bit         m_act  [2] = '{1'b0, 1'b0};
   int         m_n    [2] = '{0, 0};
   logic [3:0] m_mask [2] = '{4'b0, 4'b0};
   logic       m_pass [2] = '{1'b0, 1'b0};
   logic       m_done [2] = '{1'b0, 1'b0};
   int         m_err  [2] = '{0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic gate_fn(input int sel, input logic a, input logic b);
      case (sel)
         G_AND:   return a & b;
         G_OR:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign y_w[0] = gate_fn(gate_sel[0], a_w[0], b_w[0]);
   assign y_w[1] = gate_fn(gate_sel[1], a_w[1], b_w[1]);

   gate_sweep_ctrl #(.HOLD_CYCLES(2), .EXPECT(4'b1000)) u_h2 (
      .clk(clk), .rst(rst), .start(start_r[0]), .dut_y(y_w[0]),
      .dut_a(a_w[0]), .dut_b(b_w[0]), .vec_idx(vi_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .pass(pass_w[0]), .fail_mask(fm_w[0])
`ifdef GATE_SWEEP_ERRCNT_EN
      , .err_cnt(ec_w[0])
`endif
   );

   gate_sweep_ctrl #(.HOLD_CYCLES(1), .EXPECT(4'b0110)) u_h1 (
      .clk(clk), .rst(rst), .start(start_r[1]), .dut_y(y_w[1]),
      .dut_a(a_w[1]), .dut_b(b_w[1]), .vec_idx(vi_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .pass(pass_w[1]), .fail_mask(fm_w[1])
`ifdef GATE_SWEEP_ERRCNT_EN
      , .err_cnt(ec_w[1])
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a sweep is "n edges after E0"; vector n/H is driven, and every H-th edge
   // samples vector n/H-1 against the expectation table using the bench's own gate.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit act; int n; logic [3:0] mask; logic pass, dn; int err; int j;
         act = m_act[i]; n = m_n[i]; mask = m_mask[i]; pass = m_pass[i]; err = m_err[i];
         dn = 1'b0;
         if (rst) begin
            act = 1'b0; n = 0; mask = 4'b0; pass = 1'b0; err = 0;
         end else if (act) begin
            n = n + 1;
            if (n % h_of[i] == 0) begin
               j = n / h_of[i] - 1;
               if (gate_fn(gate_sel[i], j[0], j[1]) != exp_of[i][j]) begin
                  mask[j] = 1'b1;
                  if (err < 255) err = err + 1;
               end
            end
            if (n == 4 * h_of[i]) begin
               act  = 1'b0;
               dn   = 1'b1;
               pass = (mask == 4'b0);
            end
         end else if (start_r[i]) begin
            act = 1'b1; n = 0; mask = 4'b0; pass = 1'b0;
         end
         m_act[i]  <= act;
         m_n[i]    <= n;
         m_mask[i] <= mask;
         m_pass[i] <= pass;
         m_done[i] <= dn;
         m_err[i]  <= err;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) begin
            int k;
            k = m_act[i] ? (m_n[i] / h_of[i]) : 0;
            check($sformatf("busy%0d", i), busy_w[i], m_act[i]);
            check($sformatf("done%0d", i), done_w[i], m_done[i]);
            check($sformatf("pass%0d", i), pass_w[i], m_pass[i]);
            check($sformatf("fail_mask%0d", i), fm_w[i], m_mask[i]);
            check($sformatf("vec_idx%0d", i), vi_w[i], k[1:0]);
            check($sformatf("dut_a%0d", i), a_w[i], k[0]);
            check($sformatf("dut_b%0d", i), b_w[i], k[1]);
`ifdef GATE_SWEEP_ERRCNT_EN
            check($sformatf("err_cnt%0d", i), ec_w[i], m_err[i][7:0]);
`endif
         end
      end
   end

   // Pulse start on instance i, then wait (bounded) for done; lat = edges from E0 to done cycle.
   task automatic run_sweep(input int i, output int lat);
      int e0;
      @(negedge clk); start_r[i] = 1'b1;
      @(negedge clk); start_r[i] = 1'b0;
      e0  = cyc;
      lat = -1;
      for (int n = 0; n < 64; n++) begin
         if (n < 16) trace[n] = {b_w[i], a_w[i]};
         if (done_w[i]) begin
            lat = cyc - e0;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, ndone, e0, d1;
      rst = 1'b1;
      start_r = 2'b00;
      gate_sel[0] = G_AND;
      gate_sel[1] = G_XOR;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_busy", busy_w, 2'b00);
      check("rst_done", done_w, 2'b00);
      check("rst_pass", pass_w, 2'b00);
      check("rst_mask", {fm_w[1], fm_w[0]}, 8'h00);
      check("rst_ab", {b_w, a_w}, 4'h0);
      rst = 1'b0;

      // AND gate, default table, H=2
      run_sweep(0, lat);
      check("and_latency", lat, 8);
      check("and_pass", pass_w[0], 1'b1);
      check("and_mask", fm_w[0], 4'b0000);
      check("and_vec_n1", trace[1], 2'b00);
      check("and_vec_n2", trace[2], 2'b01);
      check("and_vec_n5", trace[5], 2'b10);
      check("and_vec_n7", trace[7], 2'b11);

      // OR gate against the AND table
      gate_sel[0] = G_OR;
      run_sweep(0, lat);
      check("or_latency", lat, 8);
      check("or_mask", fm_w[0], 4'b0110);
      check("or_model_mask", m_mask[0], 4'b0110);
      check("or_pass", pass_w[0], 1'b0);

      // XOR gate, XOR table, H=1
      run_sweep(1, lat);
      check("xor_latency", lat, 4);
      check("xor_pass", pass_w[1], 1'b1);
      check("xor_mask", fm_w[1], 4'b0000);

      // start re-pulsed at E0+3 must be ignored
      gate_sel[0] = G_AND;
      @(negedge clk); start_r[0] = 1'b1;
      @(negedge clk); start_r[0] = 1'b0;
      e0 = cyc; ndone = 0; lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (n == 2) start_r[0] = 1'b1;
         if (n == 3) start_r[0] = 1'b0;
         if (done_w[0]) begin
            ndone++;
            lat = cyc - e0;
         end
         @(negedge clk);
      end
      check("repulse_done_count", ndone, 1);
      check("repulse_latency", lat, 8);

      // rst at E0+5 aborts the sweep
      @(negedge clk); start_r[0] = 1'b1;
      @(negedge clk); start_r[0] = 1'b0;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         if (n == 4) rst = 1'b1;
         if (n == 5) begin
            check("abort_busy", busy_w[0], 1'b0);
            check("abort_vec", {b_w[0], a_w[0], vi_w[0]}, 4'h0);
            check("abort_mask_pass", {fm_w[0], pass_w[0]}, 5'h0);
            rst = 1'b0;
         end
         if (done_w[0]) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 0);
      run_sweep(0, lat);
      check("after_abort_latency", lat, 8);
      check("after_abort_pass", pass_w[0], 1'b1);

      // start held high: back-to-back OR sweeps, 130 of them
      gate_sel[0] = G_OR;
      @(negedge clk); start_r[0] = 1'b1;
      ndone = 0; d1 = 0;
      for (int n = 0; n < 130 * 9 + 50; n++) begin
         @(negedge clk);
         if (ndone == 1 && cyc == d1 + 1) begin
            check("held_restart_busy", busy_w[0], 1'b1);
            check("held_restart_mask", fm_w[0], 4'b0000);
         end
         if (done_w[0]) begin
            ndone++;
            if (ndone == 1) begin
               d1 = cyc;
               check("held_first_mask", fm_w[0], 4'b0110);
            end
            if (ndone == 2) check("held_period", cyc - d1, 9);
            if (ndone == 130) begin
               start_r[0] = 1'b0;
               break;
            end
         end
      end
      check("held_done_count", ndone, 130);
`ifdef GATE_SWEEP_ERRCNT_EN
      check("errcnt_saturated", ec_w[0], 8'd255);
      check("errcnt_clean_xor", ec_w[1], 8'd0);
      gate_sel[0] = G_AND;
      run_sweep(0, lat);
      check("errcnt_kept_on_start", ec_w[0], 8'd255);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sweep controller for a 2-input combinational gate. It sequences the gate's inputs through all four input combinations, holds each one for a programmable settle time, and samples the gate output. Each sample is compared against a parameterised truth table, and the result is reported as a per-vector fail mask and a pass flag. It sits between a run-control source (bench or host logic) and any 2-input gate instance: AND, OR or XOR, in behavioural, dataflow or structural form.

## Interface
- HOLD_CYCLES, 2, cycles each vector is driven before `dut_y` is sampled; legal range 1..255.
- EXPECT, 4'b1000, expected `dut_y` for vector k in bit k; the default is the AND truth table.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  sweep request; sampled only in IDLE
- dut_y  in  1  gate output under test
- dut_a  out  1  gate input A; equals vector index bit 0
- dut_b  out  1  gate input B; equals vector index bit 1
- vec_idx  out  2  index of the vector currently driven
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  1 when `fail_mask` is 0; valid from `done`, held until the next accepted start
- fail_mask  out  4  bit k set when the sample for vector k mismatched EXPECT[k]

## Operation
- Vector order is k = 0,1,2,3, giving (b,a) = 00, 01, 10, 11.
- States:
  - IDLE: `busy` = 0 and `dut_a`/`dut_b` = 0. On `start` = 1, go to DRIVE, clear `fail_mask` and `pass`, set k = 0 and hold count = 0.
  - DRIVE: drive vector k and increment the hold counter. When the counter reaches HOLD_CYCLES-1, do all of the following at that edge:
    - compare `dut_y` to EXPECT[k] and set `fail_mask[k]` on mismatch;
    - if k < 3, advance k and reset the counter;
    - if k = 3, go to IDLE, pulse `done`, and load `pass` = (final `fail_mask` == 0).
- `start` while `busy` is ignored and is not queued.
- Mask bits only set during a sweep; they never clear mid-sweep.
- `dut_a`, `dut_b` and `vec_idx` are registered outputs.

## Timing
- Reset values: `dut_a` = 0, `dut_b` = 0, `vec_idx` = 0, `busy` = 0, `done` = 0, `pass` = 0, `fail_mask` = 0, state IDLE, hold counter 0.
- Let the edge that samples `start` = 1 be E0:
  - vector k is driven from edge E0 + k·H to edge E0 + (k+1)·H, where H = HOLD_CYCLES;
  - `dut_y` for vector k is sampled at edge E0 + (k+1)·H;
  - `done` is high for exactly the cycle after edge E0 + 4H, and `busy` falls at that same edge.
- Total sweep latency is 4·H cycles from E0 to `done`.
- The DUT is combinational; H = 1 gives it one full cycle to settle.
- Back-to-back sweeps: `start` held high during the `done` cycle is accepted at the next edge. The gap from the end of one sweep to the next E0 is at least one cycle.
- `rst` mid-sweep: at the next edge all outputs take their reset values and no `done` is produced. `rst` dominates `start` at the same edge.

## Configuration
- GATE_SWEEP_ERRCNT_EN, when defined:
  - adds output `err_cnt` (out, 8 bits), which increments by 1 at every mismatching sample;
  - `err_cnt` saturates at 255 and accumulates across sweeps;
  - only `rst` clears it; `start` does not.
- When not defined: no `err_cnt` port or counter logic; all other behaviour is identical.

## Test plan
- Correct AND gate, defaults, `start` pulsed once:
  - (b,a) steps 00, 01, 10, 11, each held 2 cycles;
  - `done` arrives 8 cycles after E0, with `pass` = 1 and `fail_mask` = 4'b0000.
- OR gate connected with EXPECT = 4'b1000 → `fail_mask` = 4'b0110, `pass` = 0.
- XOR gate with EXPECT = 4'b0110 and H = 1 → `done` 4 cycles after E0, `pass` = 1.
- `start` re-pulsed at E0+3 → ignored: a single `done` at E0+8 and vector timing unchanged.
- `start` held high continuously, H = 2 → the second E0 is the edge right after the `done` cycle, and `fail_mask` is cleared at that edge.
- `rst` asserted at E0+5 → outputs at reset values from the next edge and no `done`. A following start sweeps normally.
- With GATE_SWEEP_ERRCNT_EN, OR gate vs the AND table, 130 sweeps → `err_cnt` = 255 (saturated), and it does not clear on `start`.
